// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial N-bit add/subtract around one fas cell; SERIAL_ADDSUB_OVF_EN enables overflow
module fas (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic a_ns,
    output logic s,
    output logic cout
);
    // Full adder when a_ns=1, full subtractor (cin/cout act as borrow) when a_ns=0
    assign s    = a ^ b ^ cin;
    assign cout = a_ns ? ((a & b) | (cin & (a ^ b)))
                       : ((~a & b) | (cin & ~(a ^ b)));
endmodule

module serial_addsub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         a_ns,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         overflow
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  sh_a;
    logic [N-1:0]  sh_b;
    logic          op_add;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          fas_s;
    logic          fas_c;
    logic          last_bit;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic          a_msb;
    logic          b_msb;
    logic          ovf_r;
    assign overflow = ovf_r;
`else
    assign overflow = 1'b0;
`endif

    assign last_bit = (cnt == CW'(N - 1));

    fas u_fas (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry),
        .a_ns (op_add),
        .s    (fas_s),
        .cout (fas_c)
    );

    // Control FSM plus operand/result datapath; every output is a register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            sh_a   <= '0;
            sh_b   <= '0;
            op_add <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a   <= a;
                        sh_b   <= b;
                        op_add <= a_ns;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
`ifdef SERIAL_ADDSUB_OVF_EN
                        a_msb  <= a[N-1];
                        b_msb  <= b[N-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    result <= {fas_s, result[N-1:1]};
                    carry  <= fas_c;
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        // fas_s here is the result MSB, so overflow is judged on this edge
                        cout  <= fas_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef SERIAL_ADDSUB_OVF_EN
                        ovf_r <= (a_msb ^ fas_s) &
                                 (op_add ? ~(a_msb ^ b_msb) : (a_msb ^ b_msb));
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub
module tb_serial_addsub;
    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         a_ns;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    serial_addsub #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_ns     (a_ns),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Reference: {overflow, cout, result} from integer arithmetic
    function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic add);
        int ux, uy, u, sx, sy, sr;
        logic [N-1:0] r;
        logic c, v;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= (1 << (N - 1))) ? ux - (1 << N) : ux;
        sy = (uy >= (1 << (N - 1))) ? uy - (1 << N) : uy;
        u  = add ? ux + uy : ux - uy;
        sr = add ? sx + sy : sx - sy;
        r  = u[N-1:0];
        c  = add ? (u > (1 << N) - 1) : (u < 0);
`ifdef SERIAL_ADDSUB_OVF_EN
        v  = (sr > (1 << (N - 1)) - 1) || (sr < -(1 << (N - 1)));
`else
        v  = 1'b0;
`endif
        return {v, c, r};
    endfunction

    // Caller sits at a negedge; returns at the negedge just after the accepting edge
    task automatic launch(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tadd);
        a     = ta;
        b     = tb_v;
        a_ns  = tadd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedge samples until done; k=-1 if it never arrives
    task automatic wait_done(output int k, output int busy_cnt);
        k = -1;
        busy_cnt = 0;
        for (int i = 0; i < 4 * N; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                k = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        a_ns = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, result, cout, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
                     busy, done, result, cout, overflow);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [N-1:0] va [5] = '{8'h25, 8'hFF, 8'h10, 8'h7F, 8'h80};
        logic [N-1:0] vb [5] = '{8'h13, 8'h01, 8'h20, 8'h01, 8'h01};
        logic         vo [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [N-1:0] er [5] = '{8'h38, 8'h00, 8'hF0, 8'h80, 8'h7F};
        logic         ec [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic         ev [5];
        int k, bc;
`ifdef SERIAL_ADDSUB_OVF_EN
        ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        ev = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 5; i++) begin
            launch(va[i], vb[i], vo[i]);
            wait_done(k, bc);
            checks++;
            if (k !== N || bc !== N) begin
                errors++;
                $display("FAIL dir%0d_timing: done_at=%0d busy_cycles=%0d, want %0d and %0d", i, k, bc, N, N);
            end
            checks++;
            if ({overflow, cout, result} !== {ev[i], ec[i], er[i]}) begin
                errors++;
                $display("FAIL dir%0d_value: got r=%h c=%b v=%b, want r=%h c=%b v=%b",
                         i, result, cout, overflow, er[i], ec[i], ev[i]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || result !== er[i]) begin
                errors++;
                $display("FAIL dir%0d_hold: done=%b busy=%b r=%h, want 0 0 %h", i, done, busy, result, er[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] ra, rb;
        logic ro;
        logic [N+1:0] exp_v;
        int k, bc;
        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            ro = 1'($urandom);
            exp_v = model(ra, rb, ro);
            launch(ra, rb, ro);
            wait_done(k, bc);
            checks++;
            if (k !== N || {overflow, cout, result} !== exp_v) begin
                errors++;
                $display("FAIL rand%0d: a=%h b=%h add=%b got k=%0d r=%h c=%b v=%b, want k=%0d r=%h c=%b v=%b",
                         i, ra, rb, ro, k, result, cout, overflow, N, exp_v[N-1:0], exp_v[N], exp_v[N+1]);
            end
            if (($urandom & 1) != 0) @(negedge clk);
        end
    endtask

    task automatic test_ignore_and_reset();
        int k, bc;
        launch(8'h25, 8'h13, 1'b1);
        @(negedge clk);
        a = 8'hAA;
        b = 8'h55;
        a_ns = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k, bc);
        checks++;
        if (k !== N - 2 || result !== 8'h38 || cout !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: k=%0d r=%h c=%b, want k=%0d r=38 c=0", k, result, cout, N - 2);
        end
        @(negedge clk);
        launch(8'hFF, 8'h01, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, cout, overflow} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b r=%h c=%b v=%b, want all 0",
                     busy, done, result, cout, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b done=%b, want 0 0", busy, done);
        end
        launch(8'h01, 8'h02, 1'b1);
        wait_done(k, bc);
        checks++;
        if (k !== N || result !== 8'h03 || cout !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_op: k=%0d r=%h c=%b, want k=%0d r=03 c=0", k, result, cout, N);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k, bc;
        launch(8'h25, 8'h13, 1'b1);
        wait_done(k, bc);
        a = 8'h05;
        b = 8'h03;
        a_ns = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_gap: busy=%b done=%b, want 1 0", busy, done);
        end
        wait_done(k, bc);
        checks++;
        if (k !== N || bc !== N || result !== 8'h02 || cout !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: k=%0d busy=%0d r=%h c=%b v=%b, want k=%0d busy=%0d r=02 c=0 v=0",
                     k, bc, result, cout, overflow, N, N);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_and_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial N-bit adder/subtractor that sits directly upstream of the team's `fas` cell and drives it. The block loads two N-bit operands and an add/subtract select, then presents one bit pair per clock to a single `fas` instance, LSB first. It registers the carry/borrow between cycles, shifts the sum/difference bits into a result register, and reports completion with a one-cycle `done` pulse.

## Interface
- `N`, default 8: operand and result width; legal for N ≥ 2.
- `clk`  in  1: rising-edge clock. Period ≥ 40 time units so that `fas` gate propagation settles.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled on a rising edge.
- `a_ns`  in  1: 1 = add (a+b), 0 = subtract (a−b); sampled with `start`.
- `a`  in  N: operand A; sampled with `start`.
- `b`  in  N: operand B; sampled with `start`.
- `busy`  out  1: high while bits are being processed.
- `done`  out  1: one-cycle pulse when `result` is valid.
- `result`  out  N: sum or difference; held until the next accepted start.
- `cout`  out  1: final carry (add) or final borrow (subtract).
- `overflow`  out  1: signed two's-complement overflow.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1.
  - DONE: `done`=1, `busy`=0.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE after N bit cycles.
  - DONE→RUN on `start`; otherwise DONE→IDLE.
- Load (start accepted in IDLE or DONE):
  - Capture A and B into shift registers.
  - Latch `a_ns`.
  - Clear the carry/borrow flip-flop to 0 in both modes.
  - Clear the bit counter.
- RUN, each edge:
  - Drive `fas` with the A and B LSBs, the registered carry, and the latched `a_ns`.
  - Shift the `fas` output `s` into `result` MSB-first, so that after N shifts bit 0 sits at `result[0]`.
  - Register `fas` `cout` as the next carry/borrow.
  - Shift A and B right; increment the counter.
- `start` while in RUN is ignored; the operands and the operation in flight are unaffected.
- On the final (Nth) RUN edge:
  - `cout` takes the last carry/borrow.
  - `overflow` = (A[N−1] ^ R[N−1]) & (add ? ~(A[N−1]^B[N−1]) : (A[N−1]^B[N−1])), using the original operand MSBs (kept in registers) and the result MSB.
- `result`, `cout` and `overflow` hold their values through DONE and IDLE and change only in the next RUN.
- Reset, asserted at any time including mid-RUN:
  - State goes to IDLE.
  - `busy`, `done`, `result`, `cout`, `overflow`, the counter and the carry all go to 0 immediately.

## Timing
- Start accepted at edge t0; bit k is processed at edge t0+1+k.
- DONE is entered at edge t0+N; `done` is high for exactly the cycle between edges t0+N and t0+N+1.
- Latency: N+1 edges from the accepting edge to the end of the `done` pulse; throughput is one operation per N+1 cycles back-to-back.
- `busy` is high from edge t0 to edge t0+N, i.e. exactly N cycles.
- All outputs are registered; none depend combinationally on inputs.
- When `rst_n` is released, the first rising edge with `start`=1 is accepted.

## Configuration
- `SERIAL_ADDSUB_OVF_EN` defined: the overflow MSB registers and logic are present, and `overflow` behaves as specified above.
- `SERIAL_ADDSUB_OVF_EN` undefined: the overflow logic and MSB registers are removed, and `overflow` is tied to 0. All other behaviour and timing are identical.

## Test plan
- Add, N=8: a=0x25, b=0x13, a_ns=1 → `result`=0x38, `cout`=0, `overflow`=0; `done` pulses exactly 8 cycles after the start edge; `busy` is high for 8 cycles.
- Carry out: a=0xFF, b=0x01, add → `result`=0x00, `cout`=1, `overflow`=0.
- Subtract with borrow: a=0x10, b=0x20, a_ns=0 → `result`=0xF0, `cout`=1, `overflow`=0.
- Signed overflow: a=0x7F, b=0x01, add → `result`=0x80, `cout`=0, `overflow`=1 (and 0 with the macro undefined). a=0x80, b=0x01, subtract → `result`=0x7F, `overflow`=1.
- Ignore and reset: pulse `start` with new operands during RUN → first result unchanged. Then drop `rst_n` after 3 RUN edges → all outputs 0, state IDLE; the next start of 0x01+0x02 gives `result`=0x03.
- Back-to-back: assert `start` in the `done` cycle with a=0x05, b=0x03, subtract → no IDLE gap, `busy` rises at the next edge, and the second `done` shows `result`=0x02, `cout`=0.
